// File: rtl/spi_sine_responder.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | spi_sine_responder                                                       |
// | SPI mode-0 slave that shifts one buffered word per CS-low frame.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module spi_sine_responder #(
   parameter int unsigned          WORD_W      = 16,
   parameter logic [WORD_W-1:0]    NODATA_WORD = 16'hFFFF,
   parameter int unsigned          SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_clk,
   input  logic              cs,
   output logic              miso,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              busy,
   output logic              done,
   output logic              abort,
   output logic              underrun
);

   localparam int unsigned          c_cnt_w    = $clog2(WORD_W + 1);
   localparam logic [c_cnt_w-1:0]   c_last_bit = c_cnt_w'(WORD_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_WAIT_CS = 2'd2
   } state_t;

   state_t                   r_state;
   logic [SYNC_STAGES-1:0]   r_sclk_sync;
   logic [SYNC_STAGES-1:0]   r_cs_sync;
   logic [SYNC_STAGES-1:0]   r_fill;
   logic                     r_sclk_prev;
   logic                     r_cs_prev;
   logic                     r_armed;
   logic [WORD_W-1:0]        r_shift;
   logic [c_cnt_w-1:0]       r_cnt;
   logic [WORD_W-1:0]        r_buf;
   logic                     r_buf_valid;
   logic                     r_from_buf;
   logic                     r_miso;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_abort;
   logic                     r_underrun;

   logic w_sclk_s, w_cs_s;
   logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
   logic w_clr, w_buf_has, w_accept;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
   assign w_cs_rise   = w_cs_s & ~r_cs_prev;
   // A start needs a genuine high-to-low CS seen after reset, not the reset value.
   assign w_cs_fall   = ~w_cs_s & r_cs_prev & r_armed;

   // The buffer empties the cycle after done, so ready stays low while done is high.
   assign w_clr       = r_done & r_from_buf;
   assign w_buf_has   = r_buf_valid & ~w_clr;
   assign w_accept    = word_valid & ~r_buf_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_fill      <= '0;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
         r_armed     <= 1'b0;
         r_shift     <= NODATA_WORD;
         r_cnt       <= '0;
         r_buf       <= '0;
         r_buf_valid <= 1'b0;
         r_from_buf  <= 1'b0;
         r_miso      <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_abort     <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         r_sclk_sync[0] <= spi_clk;
         r_cs_sync[0]   <= cs;
         r_fill[0]      <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sclk_sync[i] <= r_sclk_sync[i-1];
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_fill[i]      <= r_fill[i-1];
         end
         r_sclk_prev <= w_sclk_s;
         r_cs_prev   <= w_cs_s;
         if (r_fill[SYNC_STAGES-1] && w_cs_s)
            r_armed <= 1'b1;

         r_done     <= 1'b0;
         r_abort    <= 1'b0;
         r_underrun <= 1'b0;

         if (w_clr)
            r_buf_valid <= 1'b0;
         if (w_accept) begin
            r_buf       <= word_in;
            r_buf_valid <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  r_state <= ST_SHIFT;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  if (w_buf_has) begin
                     r_shift    <= r_buf;
                     r_miso     <= r_buf[WORD_W-1];
                     r_from_buf <= 1'b1;
                  end else if (w_accept) begin
                     // Word arriving on the start edge goes straight out and stays buffered.
                     r_shift    <= word_in;
                     r_miso     <= word_in[WORD_W-1];
                     r_from_buf <= 1'b1;
                  end else begin
                     r_shift    <= NODATA_WORD;
                     r_miso     <= NODATA_WORD[WORD_W-1];
                     r_from_buf <= 1'b0;
                     r_underrun <= 1'b1;
                  end
               end
            end
            ST_SHIFT: begin
               if (w_cs_rise) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_miso  <= 1'b1;
                  r_abort <= 1'b1;
               end else if (w_sclk_rise) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == c_last_bit)
                     r_state <= ST_WAIT_CS;
               end else if (w_sclk_fall) begin
                  r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                  r_miso  <= r_shift[WORD_W-2];
               end
            end
            ST_WAIT_CS: begin
               if (w_cs_rise) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_miso  <= 1'b1;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign miso       = r_miso;
   assign busy       = r_busy;
   assign done       = r_done;
   assign abort      = r_abort;
   assign underrun   = r_underrun;
   assign word_ready = ~r_buf_valid;

endmodule
`default_nettype wire
